// File: rtl/mram_responder.sv
// Responder-side emulation of the 16-bit asynchronous MRAM: decodes the active-low
// control strobes, commits byte-masked writes and returns read data after READ_LAT edges.
module mram_responder #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 16,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              chip_en,
    input  logic              write_en,
    input  logic              out_en,
    input  logic              lower_byte_en,
    input  logic              upper_byte_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_en,
    output logic              busy,
    output logic              conflict,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
);

    localparam int         DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] LAT   = 4'(READ_LAT);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_READ_WAIT = 2'd1,
        ST_DRIVE     = 2'd2
    } state_t;

    // Inactive lanes read as zero.
    function automatic logic [15:0] lane_mask(input logic [15:0] word, input logic [1:0] lanes);
        lane_mask = {(lanes[1] ? word[15:8] : 8'h00), (lanes[0] ? word[7:0] : 8'h00)};
    endfunction

    logic [15:0] mem [DEPTH];

    state_t              state_q, state_d;
    logic [3:0]          lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
    logic [15:0]         data_out_q, data_out_d;
    logic                data_out_en_q, data_out_en_d;
    logic                busy_q, busy_d;
    logic                conflict_q, conflict_d;
    logic [15:0]         wr_count_q, wr_count_d;
    logic [15:0]         rd_count_q, rd_count_d;

    logic [1:0]          lane_s;
    logic                access_s;
    logic                wr_s;
    logic                rd_req_s;
    logic                addr_match_s;
    logic [15:0]         masked_s;

    // Decode the sampled bus strobes into access type and active lanes.
    always_comb begin
        lane_s       = {~upper_byte_en, ~lower_byte_en};
        access_s     = ~chip_en & (lane_s != 2'b00);
        wr_s         = access_s & ~write_en;
        rd_req_s     = access_s & write_en & ~out_en;
        addr_match_s = (addr == lat_addr_q);
        masked_s     = lane_mask(mem[lat_addr_q], lane_s);
    end

    // Byte-masked write port; the array is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (wr_s && !rst) begin
            if (lane_s[0]) begin
                mem[addr][7:0] <= data_in[7:0];
            end
            if (lane_s[1]) begin
                mem[addr][15:8] <= data_in[15:8];
            end
        end
    end

    // Next-state and next-output computation; a write always overrides any read in flight.
    always_comb begin
        state_d       = state_q;
        lat_cnt_d     = lat_cnt_q;
        lat_addr_d    = lat_addr_q;
        data_out_d    = 16'h0000;
        data_out_en_d = 1'b0;
        conflict_d    = conflict_q;
        wr_count_d    = wr_count_q;
        rd_count_d    = rd_count_q;

        if (wr_s) begin
            state_d    = ST_IDLE;
            lat_cnt_d  = 4'd0;
            wr_count_d = wr_count_q + 16'd1;
            if (!out_en) begin
                conflict_d = 1'b1;
            end else begin
                conflict_d = conflict_q;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rd_req_s) begin
                        lat_addr_d = addr;
                        lat_cnt_d  = 4'd1;
                        state_d    = ST_READ_WAIT;
                    end else begin
                        state_d    = ST_IDLE;
                    end
                end
                ST_READ_WAIT: begin
                    if (!rd_req_s) begin
                        state_d   = ST_IDLE;
                        lat_cnt_d = 4'd0;
                    end else if (!addr_match_s) begin
                        lat_addr_d = addr;
                        lat_cnt_d  = 4'd1;
                        state_d    = ST_READ_WAIT;
                    end else if (lat_cnt_q == LAT) begin
                        state_d       = ST_DRIVE;
                        data_out_d    = masked_s;
                        data_out_en_d = 1'b1;
                        rd_count_d    = rd_count_q + 16'd1;
                    end else begin
                        lat_cnt_d = lat_cnt_q + 4'd1;
                    end
                end
                ST_DRIVE: begin
                    if (!rd_req_s) begin
                        state_d   = ST_IDLE;
                        lat_cnt_d = 4'd0;
                    end else if (!addr_match_s) begin
                        lat_addr_d = addr;
                        lat_cnt_d  = 4'd1;
                        state_d    = ST_READ_WAIT;
                    end else begin
                        // Lane changes show up one edge later, without a new latency.
                        data_out_d    = masked_s;
                        data_out_en_d = 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    lat_cnt_d = 4'd0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // FSM and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            lat_cnt_q     <= 4'd0;
            lat_addr_q    <= '0;
            data_out_q    <= 16'h0000;
            data_out_en_q <= 1'b0;
            busy_q        <= 1'b0;
            conflict_q    <= 1'b0;
            wr_count_q    <= 16'h0000;
            rd_count_q    <= 16'h0000;
        end else begin
            state_q       <= state_d;
            lat_cnt_q     <= lat_cnt_d;
            lat_addr_q    <= lat_addr_d;
            data_out_q    <= data_out_d;
            data_out_en_q <= data_out_en_d;
            busy_q        <= busy_d;
            conflict_q    <= conflict_d;
            wr_count_q    <= wr_count_d;
            rd_count_q    <= rd_count_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_out_en = data_out_en_q;
    assign busy        = busy_q;
    assign conflict    = conflict_q;
    assign wr_count    = wr_count_q;
    assign rd_count    = rd_count_q;

endmodule

// File: tb/tb_mram_responder.sv
// Directed bench for mram_responder: a read-age model predicts every output each cycle,
// and literal expectations pin the model at the key points of each scenario.
module tb_mram_responder;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic [19:0] addr;
    logic [15:0] data_in;
    logic        chip_en, write_en, out_en, lower_byte_en, upper_byte_en;
    logic [15:0] data_out;
    logic        data_out_en, busy, conflict;
    logic [15:0] wr_count, rd_count;

    int n_tests = 0;
    int n_fail  = 0;

    mram_responder #(.ADDR_W(20), .DATA_W(16), .READ_LAT(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .data_in       (data_in),
        .chip_en       (chip_en),
        .write_en      (write_en),
        .out_en        (out_en),
        .lower_byte_en (lower_byte_en),
        .upper_byte_en (upper_byte_en),
        .data_out      (data_out),
        .data_out_en   (data_out_en),
        .busy          (busy),
        .conflict      (conflict),
        .wr_count      (wr_count),
        .rd_count      (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the array, plus "a read of m_addr has been requested for m_age edges".
    bit [15:0] m_mem [int];
    bit        m_reading;
    int        m_addr;
    int        m_age;
    bit [15:0] e_dout, e_wrc, e_rdc;
    bit        e_den, e_busy, e_conf;

    function automatic bit [15:0] mem_rd(input int a);
        return m_mem.exists(a) ? m_mem[a] : 16'h0000;
    endfunction

    task automatic model_step();
        bit        acc, wr, rd;
        bit [15:0] mk;
        int        a;
        if (rst) begin
            m_reading = 1'b0; m_age = 0;
            e_wrc = 16'h0; e_rdc = 16'h0; e_conf = 1'b0;
        end else begin
            a   = int'(addr);
            mk  = {{8{~upper_byte_en}}, {8{~lower_byte_en}}};
            acc = !chip_en && (!lower_byte_en || !upper_byte_en);
            wr  = acc && !write_en;
            rd  = acc && write_en && !out_en;
            if (wr) begin
                m_mem[a]  = (mem_rd(a) & ~mk) | (data_in & mk);
                e_wrc     = e_wrc + 16'd1;
                if (!out_en) e_conf = 1'b1;
                m_reading = 1'b0;
            end else if (rd) begin
                if (m_reading && a == m_addr) begin
                    if (m_age < LAT) begin
                        m_age = m_age + 1;
                        if (m_age == LAT) e_rdc = e_rdc + 16'd1;
                    end
                end else begin
                    m_reading = 1'b1; m_addr = a; m_age = 0;
                end
            end else begin
                m_reading = 1'b0;
            end
            e_den  = m_reading && (m_age == LAT);
            e_dout = e_den ? (mem_rd(m_addr) & mk) : 16'h0000;
        end
        if (rst) begin
            e_den = 1'b0; e_dout = 16'h0000;
        end
        e_busy = m_reading;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("m_den",  {31'd0, data_out_en}, {31'd0, e_den});
        chk("m_dout", {16'd0, data_out},    {16'd0, e_dout});
        chk("m_busy", {31'd0, busy},        {31'd0, e_busy});
        chk("m_conf", {31'd0, conflict},    {31'd0, e_conf});
        chk("m_wrc",  {16'd0, wr_count},    {16'd0, e_wrc});
        chk("m_rdc",  {16'd0, rd_count},    {16'd0, e_rdc});
    endtask

    task tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input logic ce, input logic we, input logic oe, input logic lb,
                         input logic ub, input logic [19:0] a, input logic [15:0] d);
        chip_en = ce; write_en = we; out_en = oe;
        lower_byte_en = lb; upper_byte_en = ub; addr = a; data_in = d;
    endtask

    task automatic idle();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 20'h0, 16'h0000);
    endtask

    task automatic rd_both(input logic [19:0] a);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a, 16'h0000);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        m_reading = 1'b0; m_age = 0; m_addr = 0;
        e_dout = 16'h0; e_den = 1'b0; e_busy = 1'b0; e_conf = 1'b0; e_wrc = 16'h0; e_rdc = 16'h0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_dout", {16'd0, data_out}, 32'h0);
        chk("rst_den",  {31'd0, data_out_en}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_cnts", {wr_count, rd_count}, 32'h0);

        // Full-word write then read with READ_LAT=2.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00005, 16'hA5C3); tick();
        idle(); tick();
        rd_both(20'h00005); tick();
        chk("t1_e0_den",  {31'd0, data_out_en}, 32'h0);
        chk("t1_e0_busy", {31'd0, busy}, 32'h1);
        tick();
        chk("t1_e1_den",  {31'd0, data_out_en}, 32'h0);
        tick();
        chk("t1_e2_den",  {31'd0, data_out_en}, 32'h1);
        chk("t1_dout",    {16'd0, data_out}, 32'h0000A5C3);
        chk("t1_cnts",    {wr_count, rd_count}, 32'h00010001);
        idle(); tick();
        chk("t1_idle_den", {31'd0, data_out_en}, 32'h0);

        // Lower-lane write, full read, then drop the lower lane while driving.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 20'h00005, 16'h00FF); tick();
        rd_both(20'h00005); tick(); tick(); tick();
        chk("t2_dout_both", {16'd0, data_out}, 32'h0000A5FF);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 20'h00005, 16'h0000); tick();
        chk("t2_dout_upper", {16'd0, data_out}, 32'h0000A500);
        chk("t2_rdc", {16'd0, rd_count}, 32'h2);
        idle(); tick();

        // Simultaneous write and output enable: write wins, conflict is sticky.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00010, 16'h1234); tick();
        chk("t3_conf", {31'd0, conflict}, 32'h1);
        chk("t3_wrc",  {16'd0, wr_count}, 32'h3);
        idle(); tick();

        // Address change while driving restarts the latency.
        rd_both(20'h00005); tick(); tick(); tick();
        chk("t4_dout5", {16'd0, data_out}, 32'h0000A5FF);
        rd_both(20'h00010); tick();
        chk("t4_chg_den0", {31'd0, data_out_en}, 32'h0);
        tick();
        chk("t4_chg_den1", {31'd0, data_out_en}, 32'h0);
        tick();
        chk("t4_new_den",  {31'd0, data_out_en}, 32'h1);
        chk("t4_new_dout", {16'd0, data_out}, 32'h00001234);
        chk("t4_rdc",  {16'd0, rd_count}, 32'h4);
        chk("t4_conf", {31'd0, conflict}, 32'h1);

        // Write during DRIVE aborts the read; read-after-write sees the new data.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00020, 16'hBEEF); tick();
        chk("ab_den",  {31'd0, data_out_en}, 32'h0);
        chk("ab_busy", {31'd0, busy}, 32'h0);
        rd_both(20'h00020); tick(); tick(); tick();
        chk("raw_dout", {16'd0, data_out}, 32'h0000BEEF);
        chk("raw_rdc",  {16'd0, rd_count}, 32'h5);

        // Read abandoned in READ_WAIT leaves rd_count alone.
        idle(); tick();
        rd_both(20'h00005); tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00005, 16'h0000); tick();
        chk("abn_busy", {31'd0, busy}, 32'h0);
        chk("abn_rdc",  {16'd0, rd_count}, 32'h5);
        idle(); tick();

        // Asynchronous reset during READ_WAIT; the array survives.
        rd_both(20'h00005); tick();
        chk("r_pre_busy", {31'd0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        chk("r_den",  {31'd0, data_out_en}, 32'h0);
        chk("r_busy", {31'd0, busy}, 32'h0);
        chk("r_conf", {31'd0, conflict}, 32'h0);
        tick();
        rst = 1'b0;
        idle(); tick();
        rd_both(20'h00005); tick(); tick(); tick();
        chk("r_dout", {16'd0, data_out}, 32'h0000A5FF);
        chk("r_cnts", {wr_count, rd_count}, 32'h00000001);
        idle(); tick();

        // 65536 writes wrap wr_count; a write with no lane enabled is ignored.
        for (int i = 0; i < 65536; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h01000 + 20'(i), 16'(i) ^ 16'h5A5A);
            tick();
            if (i == 65534) chk("w_ffff", {16'd0, wr_count}, 32'h0000FFFF);
        end
        chk("w_wrap", {16'd0, wr_count}, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 20'h00005, 16'hFFFF); tick();
        chk("w_nolane", {16'd0, wr_count}, 32'h0);
        rd_both(20'h00005); tick(); tick(); tick();
        chk("w_mem5", {16'd0, data_out}, 32'h0000A5FF);
        idle(); tick();
        rd_both(20'h01007); tick(); tick(); tick();
        chk("w_mem1007", {16'd0, data_out}, 32'h00005A5D);
        idle(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mram_responder.md
Name: mram_responder

Overview:
- Synthesizable emulator of the 16-bit asynchronous-style MRAM, acting as the responder to the MRAM control bus.
- Decodes the active-low chip/write/output/byte-lane enables, commits byte-masked writes into an internal array, and returns read data after a programmable latency.
- Drives a registered output bus with an explicit drive-enable.
- Replaces the physical MRAM in on-FPGA loopback builds and in the control-module regression bench.

Parameters:
- ADDR_W, 20, address width; the array holds 2**ADDR_W words (synthesis builds override to 10).
- DATA_W, 16, word width; fixed at 16 (two byte lanes).
- READ_LAT, 2, clock edges from the read-sampling edge to the first valid data_out; legal range 1..15.

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  asynchronous reset, active-high
- addr  in  ADDR_W  word address from the controller
- data_in  in  16  write data from the controller
- chip_en  in  1  chip enable, active low
- write_en  in  1  write enable, active low
- out_en  in  1  output (read) enable, active low
- lower_byte_en  in  1  lane [7:0] enable, active low
- upper_byte_en  in  1  lane [15:8] enable, active low
- data_out  out  16  read data, registered
- data_out_en  out  1  high while data_out is valid and driven
- busy  out  1  high in READ_WAIT and DRIVE
- conflict  out  1  sticky: write_en and out_en were both low with chip_en low
- wr_count  out  16  committed-write counter, wraps 0xFFFF->0x0000
- rd_count  out  16  completed-read counter (DRIVE entries), wraps

Behaviour:
- Reset: a clk/rst sensitivity list with rst=1 forces state IDLE, data_out=0, data_out_en=0, busy=0, conflict=0, wr_count=0, rd_count=0, latency counter=0.
- The memory array is not cleared by rst. It is zero at configuration/sim start.
- Inputs are sampled on each rising edge. An access is any cycle with chip_en=0 and at least one byte enable low. Otherwise the cycle is a no-access.
- Lane mask: lane L is active when its enable is 0. Inactive lanes read as 0x00 on data_out and are never written.
- Write (chip_en=0, write_en=0, any lane active):
  - Commits on that edge: mem[addr] is updated on active lanes only; wr_count increments.
  - Legal in any state. A write aborts any pending or driving read: state goes to IDLE, data_out_en=0 and data_out=0 on the same edge.
  - If out_en=0 simultaneously, the write still wins and conflict is set (sticky until rst).
- Read request (chip_en=0, write_en=1, out_en=0, any lane active) while in IDLE: latch addr and lane mask, set lat_cnt=1, go to READ_WAIT, busy=1 on the same edge.
- READ_WAIT:
  - Each edge with the read still requested and addr equal to the latched addr: lat_cnt increments.
  - When lat_cnt reaches READ_LAT: go to DRIVE, load data_out with the masked mem[latched addr], set data_out_en=1, rd_count+1.
  - With READ_LAT=1, data appears on the edge after the sampling edge.
- DRIVE:
  - Holds data_out and data_out_en=1 while the read remains requested with an unchanged addr.
  - data_out refreshes each edge with the current lane mask, so it reflects a lane-enable change one edge later without a new latency.
- Address change during READ_WAIT or DRIVE (read still requested): treated as a new access. Latch the new addr, lat_cnt=1, state READ_WAIT, data_out_en=0, data_out=0 on that edge.
- Read abandoned (chip_en=1, out_en=1, or both lanes inactive) in READ_WAIT or DRIVE: IDLE, busy=0, data_out_en=0, data_out=0 on that edge. rd_count is unchanged if the read never reached DRIVE.
- No-access or chip_en=1 in IDLE: outputs hold at idle values.
- Read and write to the same address: a write followed by a read on the next edge returns the new data.
- States: IDLE, READ_WAIT, DRIVE. All outputs registered; no combinational path from inputs to outputs.
- Reset asserted mid-read: immediate IDLE with data_out_en=0. The array keeps its contents.

Test Plan:
- Write addr=0x00005, data_in=0xA5C3, both lanes low, one cycle; then read addr 0x00005 with READ_LAT=2 -> data_out_en rises 2 edges after the read-sampling edge, data_out=0xA5C3, wr_count=1, rd_count=1.
- Write 0x00FF to addr 0x00005 with only lower_byte_en=0, then read both lanes -> 0xA5FF. Read with only upper_byte_en=0 -> 0xA500.
- Assert write_en=0 and out_en=0 together with data 0x1234 at addr 0x00010 -> mem[0x10]=0x1234, conflict=1 and stays 1 after later clean reads until rst.
- Read addr 0x00005 and, while in DRIVE, change addr to 0x00010 -> data_out_en drops for READ_LAT edges, then data_out=0x1234 with rd_count incremented by 1.
- Assert rst during READ_WAIT -> data_out_en=0, busy=0 immediately. After release, a read of 0x00005 still returns 0xA5FF.
- Perform 65536 writes -> wr_count wraps to 0x0000. Then a write with both byte enables high -> no memory change and no count increment.
